// File: rtl/dkong_dl_pkg.sv
// Shared definitions for the Donkey Kong ROM download writer.
package dkong_dl_pkg;

  localparam int DL_ADDR_W = 19;
  localparam int DL_CSUM_W = 16;

  typedef enum logic [1:0] {
    DL_IDLE = 2'd0,
    DL_RECV = 2'd1,
    DL_WR   = 2'd2,
    DL_DONE = 2'd3
  } dl_state_e;

endpackage

// File: rtl/dkong_rom_dl.sv
// ROM download writer: turns a valid/ready byte stream into sequential
// single-cycle writes on the shared ROM RAM port A, with count/checksum.
module dkong_rom_dl
  import dkong_dl_pkg::*;
#(
  parameter int          ADDR_W   = DL_ADDR_W,
  parameter int unsigned MAX_ADDR = (1 << ADDR_W) - 1
) (
  input  logic                 W_CLK_12288M,
  input  logic                 W_RESETn,
  input  logic                 dl_start,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [ADDR_W-1:0]    dn_addr,
  output logic [7:0]           dn_data,
  output logic                 dn_wr,
  output logic                 dl_busy,
  output logic                 dl_done,
  output logic                 dl_err,
  output logic [ADDR_W:0]      dl_count,
  output logic [DL_CSUM_W-1:0] dl_csum
);

  // Count is one bit wider than the address so a full image does not wrap.
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_ADDR);

  dl_state_e state_reg;
  logic      last_reg;
  logic      in_range;

  assign in_range = (dl_count <= MAX_CNT);

  // Status is decoded straight from the state register; DONE persists until
  // the next start, which gives the sticky done behaviour for free.
  assign s_ready = (state_reg == DL_RECV);
  assign dl_busy = (state_reg == DL_RECV) || (state_reg == DL_WR);
  assign dl_done = (state_reg == DL_DONE);

  // Download sequencer and count/checksum datapath. dn_wr doubles as the
  // latched in-range flag for the byte held during the WR cycle.
  always_ff @(posedge W_CLK_12288M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      state_reg <= DL_IDLE;
      last_reg  <= 1'b0;
      dn_addr   <= '0;
      dn_data   <= '0;
      dn_wr     <= 1'b0;
      dl_err    <= 1'b0;
      dl_count  <= '0;
      dl_csum   <= '0;
    end else begin
      case (state_reg)
        DL_IDLE, DL_DONE: begin
          if (dl_start) begin
            dn_addr   <= '0;
            dl_count  <= '0;
            dl_csum   <= '0;
            dl_err    <= 1'b0;
            state_reg <= DL_RECV;
          end
        end
        DL_RECV: begin
          if (s_valid) begin
            dn_data  <= s_data;
            last_reg <= s_last;
            // Out-of-range bytes leave dn_addr on the last written address.
            if (in_range) begin
              dn_wr   <= 1'b1;
              dn_addr <= dl_count[ADDR_W-1:0];
            end
            state_reg <= DL_WR;
          end
        end
        DL_WR: begin
          dn_wr <= 1'b0;
          if (dn_wr) begin
            dl_count <= dl_count + (ADDR_W + 1)'(1);
            dl_csum  <= dl_csum + DL_CSUM_W'(dn_data);
          end else begin
            dl_err <= 1'b1;
          end
          state_reg <= last_reg ? DL_DONE : DL_RECV;
        end
        default: state_reg <= DL_IDLE;
      endcase
    end
  end

endmodule
